// File: rtl/c3lib_ckdiv_gf.sv
// ---------------------------------------------------------------------------
// c3lib_ckdiv_gf
// Glitch-free programmable integer clock divider. It drives the c3lib clock
// inverter/buffer cells. The divided clock is always a flop Q. Ratio changes,
// enable and disable take effect only at divided-clock period boundaries, so
// no runt pulses reach the clock tree. Divide-by-1 is not supported: a loaded
// ratio of 0 or 1 is stored as 2.
//
// Optional feature (macro C3LIB_CKDIV_SYNC_EN): adds the div_sync output. It
// is a registered one-clk pulse on each rising edge of clk_div_out.
//
// Ports:
//   clk          source clock
//   rst_n        asynchronous active-low reset
//   div_en       level; 1 = run, 0 = stop after the current period
//   div_ratio    requested ratio N, sampled when div_load=1
//   div_load     one-cycle request to adopt div_ratio
//   div_busy     a loaded ratio is pending and not yet active
//   div_active   divider running (RUN or DRAIN)
//   div_sync     (C3LIB_CKDIV_SYNC_EN only) phase marker pulse
//   clk_div_out  divided clock, registered
// ---------------------------------------------------------------------------
module c3lib_ckdiv_gf #(
    parameter int unsigned DIV_W         = 4,
    parameter int unsigned DEFAULT_RATIO = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             div_busy,
    output logic             div_active,
`ifdef C3LIB_CKDIV_SYNC_EN
    output logic             div_sync,
`endif
    output logic             clk_div_out
);

    localparam logic [DIV_W-1:0] RATIO_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] RATIO_DEF = DIV_W'(DEFAULT_RATIO);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state,      state_nxt;
    logic [DIV_W-1:0] cnt,        cnt_nxt;
    logic [DIV_W-1:0] act_ratio,  act_nxt;
    logic [DIV_W-1:0] pend_ratio, pend_nxt;
    logic             busy_nxt;
    logic             active_nxt;
    logic             out_nxt;
    logic             wrap;
    logic             apply;
    logic [DIV_W-1:0] ratio_clamped;
`ifdef C3LIB_CKDIV_SYNC_EN
    logic             sync_nxt;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            cnt         <= '0;
            act_ratio   <= RATIO_DEF;
            pend_ratio  <= '0;
            div_busy    <= 1'b0;
            div_active  <= 1'b0;
            clk_div_out <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            act_ratio   <= act_nxt;
            pend_ratio  <= pend_nxt;
            div_busy    <= busy_nxt;
            div_active  <= active_nxt;
            clk_div_out <= out_nxt;
        end
    end

`ifdef C3LIB_CKDIV_SYNC_EN
    // Phase marker register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_sync <= 1'b0;
        end else begin
            div_sync <= sync_nxt;
        end
    end
`endif

    // Next-state, counter, ratio handoff and output decode
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        act_nxt       = act_ratio;
        pend_nxt      = pend_ratio;
        busy_nxt      = div_busy;
        ratio_clamped = (div_ratio < RATIO_MIN) ? RATIO_MIN : div_ratio;

        // Period boundary: last count of the active ratio while running
        wrap  = (state != ST_OFF) && (cnt == (act_ratio - ONE));
        // A pending ratio is adopted at a wrap, or on any edge while stopped
        apply = div_busy && ((state == ST_OFF) || wrap);

        if (apply) begin
            act_nxt = pend_ratio;
        end

        // A load arriving with an apply becomes the next pending value
        if (div_load) begin
            pend_nxt = ratio_clamped;
            busy_nxt = 1'b1;
        end else if (apply) begin
            busy_nxt = 1'b0;
        end

        case (state)
            ST_OFF: begin
                cnt_nxt = '0;
                if (div_en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_nxt = wrap ? '0 : (cnt + ONE);
                if (!div_en) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_nxt = wrap ? '0 : (cnt + ONE);
                if (div_en) begin
                    state_nxt = ST_RUN;
                end else if (wrap) begin
                    state_nxt = ST_OFF;
                end
            end
            default: begin
                state_nxt = ST_OFF;
                cnt_nxt   = '0;
            end
        endcase

        active_nxt = (state_nxt != ST_OFF);
        // High for the first floor(N/2) counts of each period
        out_nxt    = active_nxt && (cnt_nxt < (act_nxt >> 1));
`ifdef C3LIB_CKDIV_SYNC_EN
        sync_nxt   = active_nxt && (cnt_nxt == '0) && ((state == ST_OFF) || wrap);
`endif
    end

endmodule

// File: tb/tb_c3lib_ckdiv_gf.sv
// ---------------------------------------------------------------------------
// tb_c3lib_ckdiv_gf
// Self-checking bench for c3lib_ckdiv_gf (DIV_W=4, DEFAULT_RATIO=2). A
// behavioural reference pushes the expected outputs for every clock edge into
// a queue. They are popped and compared 1 ns after the edge. Directed pulse
// width measurements back up the per-cycle comparison.
// ---------------------------------------------------------------------------
module tb_c3lib_ckdiv_gf;

    logic       clk;
    logic       rst_n;
    logic       div_en;
    logic [3:0] div_ratio;
    logic       div_load;
    logic       div_busy;
    logic       div_active;
    logic       clk_div_out;
`ifdef C3LIB_CKDIV_SYNC_EN
    logic       div_sync;
`endif

    c3lib_ckdiv_gf #(
        .DIV_W         (4),
        .DEFAULT_RATIO (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_en      (div_en),
        .div_ratio   (div_ratio),
        .div_load    (div_load),
        .div_busy    (div_busy),
        .div_active  (div_active),
`ifdef C3LIB_CKDIV_SYNC_EN
        .div_sync    (div_sync),
`endif
        .clk_div_out (clk_div_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic prev_out = 1'b0;
    logic cur_out  = 1'b0;

    // expected {clk_div_out, div_busy, div_active, div_sync}
    logic [3:0] exp_q[$];

    // reference model state (0=OFF, 1=RUN, 2=DRAIN)
    int         m_state;
    logic [3:0] m_cnt, m_act, m_pend;
    logic       m_busy, m_out, m_sync;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 4'd0;
        m_act   = 4'd2;
        m_pend  = 4'd0;
        m_busy  = 1'b0;
        m_out   = 1'b0;
        m_sync  = 1'b0;
        exp_q.delete();
    endtask

    // Advance the reference by one clk edge using the current inputs
    task automatic model_edge();
        bit         at_end;
        bit         take;
        int         n_state;
        logic [3:0] n_cnt;
        logic [3:0] n_act;
        at_end  = (m_state != 0) && (m_cnt == m_act - 4'd1);
        take    = m_busy && (m_state == 0 || at_end);
        n_act   = take ? m_pend : m_act;
        n_state = m_state;
        n_cnt   = 4'd0;
        if (m_state == 0) begin
            n_state = div_en ? 1 : 0;
        end else begin
            n_cnt = at_end ? 4'd0 : m_cnt + 4'd1;
            if (div_en)            n_state = 1;
            else if (m_state == 1) n_state = 2;
            else if (at_end)       n_state = 0;
        end
        if (div_load) begin
            m_pend = (div_ratio < 4'd2) ? 4'd2 : div_ratio;
            m_busy = 1'b1;
        end else if (take) begin
            m_busy = 1'b0;
        end
        m_sync  = (n_state != 0) && (n_cnt == 4'd0) && (m_state == 0 || at_end);
        m_out   = (n_state != 0) && (n_cnt < (n_act >> 1));
        m_state = n_state;
        m_cnt   = n_cnt;
        m_act   = n_act;
        exp_q.push_back({m_out, m_busy, (m_state != 0), m_sync});
    endtask

    task automatic step();
        logic [3:0] e;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        e = exp_q.pop_front();
        prev_out = cur_out;
        cur_out  = clk_div_out;
        check($sformatf("out@%0d", cyc),    clk_div_out, e[3]);
        check($sformatf("busy@%0d", cyc),   div_busy,    e[2]);
        check($sformatf("active@%0d", cyc), div_active,  e[1]);
`ifdef C3LIB_CKDIV_SYNC_EN
        check($sformatf("sync@%0d", cyc),   div_sync,    e[0]);
`endif
    endtask

    task automatic load(input logic [3:0] r);
        div_ratio = r;
        div_load  = 1'b1;
        step();
        div_load  = 1'b0;
    endtask

    // Wait for the next rising edge of the output, then time one full period
    task automatic measure(input string tag, input int hi_exp, input int lo_exp);
        int hi    = 0;
        int lo    = 0;
        int guard = 0;
        do begin
            step();
            guard++;
        end while (!(prev_out == 1'b0 && cur_out == 1'b1) && guard < 64);
        while (cur_out == 1'b1 && guard < 64) begin
            hi++;
            step();
            guard++;
        end
        while (cur_out == 1'b0 && guard < 64) begin
            lo++;
            step();
            guard++;
        end
        check({tag, "_hi"}, hi, hi_exp);
        check({tag, "_lo"}, lo, lo_exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        div_en    = 1'b0;
        div_ratio = 4'd0;
        div_load  = 1'b0;
        model_reset();
        #12;
        check("rst_out",    clk_div_out, 1'b0);
        check("rst_busy",   div_busy,    1'b0);
        check("rst_active", div_active,  1'b0);
`ifdef C3LIB_CKDIV_SYNC_EN
        check("rst_sync",   div_sync,    1'b0);
`endif
        rst_n = 1'b1;
        step();
        step();
        check("off_out", clk_div_out, 1'b0);

        // Enable with default ratio 2: 1,0,1,0 starting at the sampling edge
        div_en = 1'b1;
        step();
        check("en_first",  clk_div_out, 1'b1);
        check("en_active", div_active,  1'b1);
        step();
        check("tog_0", clk_div_out, 1'b0);
        step();
        check("tog_1", clk_div_out, 1'b1);
        step();
        check("tog_2", clk_div_out, 1'b0);

        // Ratio 5 loaded at a wrap edge of N=2: pending until the next wrap
        load(4'd5);
        check("n5_busy", div_busy, 1'b1);
        measure("n5", 2, 3);
        check("n5_idle", div_busy, 1'b0);

        // Clamped loads and the maximum ratio
        load(4'd0);
        measure("n0", 1, 1);
        load(4'd1);
        measure("n1", 1, 1);
        load(4'd15);
        measure("n15", 7, 8);

        // Two loads before a wrap: only the newer one is adopted
        load(4'd3);
        check("two_busy_a", div_busy, 1'b1);
        load(4'd7);
        check("two_busy_b", div_busy, 1'b1);
        measure("two", 3, 4);

        // Drain with N=6: disable at cnt=1, the period still completes
        load(4'd6);
        measure("n6", 3, 3);
        step();
        div_en = 1'b0;
        step();
        check("drain_active", div_active, 1'b1);
        check("drain_high",   clk_div_out, 1'b1);
        repeat (4) step();
        check("drain_off_active", div_active,  1'b0);
        check("drain_off_out",    clk_div_out, 1'b0);

        // Restart, then re-enable during DRAIN for an uninterrupted waveform
        div_en = 1'b1;
        measure("rearm", 3, 3);
        step();
        step();
        div_en = 1'b0;
        step();
        div_en = 1'b1;
        step();
        check("redrain_active", div_active, 1'b1);
        measure("redrain", 3, 3);

        // Asynchronous reset in the middle of a high phase
        #2;
        check("pre_rst_high", clk_div_out, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_out",    clk_div_out, 1'b0);
        check("arst_active", div_active,  1'b0);
        check("arst_busy",   div_busy,    1'b0);
        model_reset();
        div_en   = 1'b0;
        cur_out  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        div_en = 1'b1;
        measure("post_rst", 1, 1);
        measure("post_rst2", 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
